obuf_array_sink: RTL and testbench

//   Output-buffer end of the array-to-output-buffer result path. Accepts result rows

---
 rtl/obuf_array_sink_pkg.sv | 14 +
 rtl/obuf_row_acc.sv | 20 ++
 rtl/obuf_array_sink.sv | 112 +++++++++++
 tb/tb_obuf_array_sink.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_array_sink_pkg.sv
// Shared types and sizing for the array-to-output-buffer result path.
package obuf_array_sink_pkg;

   localparam int OBUF_COLS  = 16;
   localparam int OBUF_ACC_W = 32;
   localparam int OBUF_DEPTH = 32;
   localparam int OBUF_AW    = $clog2(OBUF_DEPTH);

   typedef logic [OBUF_ACC_W-1:0] acc_t;
   typedef acc_t [OBUF_COLS-1:0]  orow_t;

   typedef enum logic {OB_FILL, OB_DRAIN} obuf_state_e;

endpackage

// File: rtl/obuf_row_acc.sv
// Lane-wise add or pass-through of one result row; each lane wraps independently.
module obuf_row_acc
   import obuf_array_sink_pkg::*;
(
   input  orow_t old_row,
   input  orow_t new_row,
   input  logic  acc_en,
   output orow_t next_row
);

   always_comb begin
      next_row = new_row;
      if (acc_en) begin
         for (int i = 0; i < OBUF_COLS; i++) begin
            next_row[i] = old_row[i] + new_row[i];
         end
      end
   end

endmodule

// File: rtl/obuf_array_sink.sv
// Output buffer: collects/accumulates result rows for one tile, then streams them out.
//
// state    | meaning
// OB_FILL  | accepting rows from the array, write or accumulate into the store
// OB_DRAIN | streaming rows 0..hw-1 downstream, array side stalled
module obuf_array_sink
   import obuf_array_sink_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             arr_valid,
   output logic                             arr_ready,
   input  logic [OBUF_AW-1:0]               arr_addr,
   input  logic [OBUF_COLS*OBUF_ACC_W-1:0]  arr_data,
   input  logic                             arr_acc,
   input  logic                             arr_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [OBUF_AW-1:0]               out_addr,
   output logic [OBUF_COLS*OBUF_ACC_W-1:0]  out_data,
   output logic                             out_last,
   output logic                             tile_done,
   output logic                             busy
);

   localparam int AW   = OBUF_AW;
   localparam int HW_W = AW + 1;
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);
   localparam logic [HW_W-1:0] HW_ONE  = HW_W'(1);

   obuf_state_e           state;
   orow_t                 store [OBUF_DEPTH];
   logic [OBUF_DEPTH-1:0] row_vld;
   logic [HW_W-1:0]       hw;
   logic [AW-1:0]         rd_ptr;

   orow_t                 old_row;
   orow_t                 wr_row;
   logic                  acc_en;
   logic                  wr_en;
   logic                  in_drain;
   logic [HW_W-1:0]       addr_p1;

   assign in_drain  = (state == OB_DRAIN);
   assign arr_ready = (state == OB_FILL) & ~rst;
   assign out_valid = in_drain;
   assign busy      = in_drain;

   assign wr_en   = arr_valid & arr_ready;
   assign old_row = store[arr_addr];
   assign acc_en  = arr_acc & row_vld[arr_addr];
   assign addr_p1 = {1'b0, arr_addr} + HW_ONE;

   // rd_ptr is held at 0 outside DRAIN, so out_addr needs no extra gating
   assign out_addr = rd_ptr;
   assign out_last = in_drain && ({1'b0, rd_ptr} == (hw - HW_ONE));
   assign out_data = (in_drain && row_vld[rd_ptr]) ? store[rd_ptr] : '0;

   obuf_row_acc u_row_acc (
      .old_row  (old_row),
      .new_row  (orow_t'(arr_data)),
      .acc_en   (acc_en),
      .next_row (wr_row)
   );

   always_ff @(posedge clk) begin
      if (wr_en) begin
         store[arr_addr] <= wr_row;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= OB_FILL;
         row_vld   <= '0;
         hw        <= '0;
         rd_ptr    <= '0;
         tile_done <= 1'b0;
      end else begin
         tile_done <= 1'b0;
         case (state)
            OB_FILL: begin
               if (wr_en) begin
                  row_vld[arr_addr] <= 1'b1;
                  if (addr_p1 > hw) begin
                     hw <= addr_p1;
                  end
                  if (arr_last) begin
                     state  <= OB_DRAIN;
                     rd_ptr <= '0;
                  end
               end
            end
            OB_DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     row_vld   <= '0;
                     hw        <= '0;
                     rd_ptr    <= '0;
                     state     <= OB_FILL;
                     tile_done <= 1'b1;
                  end else begin
                     rd_ptr <= rd_ptr + PTR_ONE;
                  end
               end
            end
            default: state <= OB_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_obuf_array_sink.sv
// Directed bench for obuf_array_sink: fill/accumulate tiles and check the drained stream.
module tb_obuf_array_sink;
   import obuf_array_sink_pkg::*;

   localparam int AW = OBUF_AW;
   localparam int W  = OBUF_COLS * OBUF_ACC_W;

   logic          clk = 1'b0;
   logic          rst;
   logic          arr_valid;
   logic          arr_ready;
   logic [AW-1:0] arr_addr;
   logic [W-1:0]  arr_data;
   logic          arr_acc;
   logic          arr_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          tile_done;
   logic          busy;

   int    n_assert = 0;
   int    n_fail   = 0;
   orow_t exp_rows [OBUF_DEPTH];

   obuf_array_sink dut (
      .clk       (clk),
      .rst       (rst),
      .arr_valid (arr_valid),
      .arr_ready (arr_ready),
      .arr_addr  (arr_addr),
      .arr_data  (arr_data),
      .arr_acc   (arr_acc),
      .arr_last  (arr_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_last  (out_last),
      .tile_done (tile_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic orow_t row_lanes(input int r);
      orow_t x;
      for (int i = 0; i < OBUF_COLS; i++) x[i] = acc_t'(16 * r + i);
      return x;
   endfunction

   function automatic orow_t row_const(input acc_t v);
      orow_t x;
      for (int i = 0; i < OBUF_COLS; i++) x[i] = v;
      return x;
   endfunction

   task automatic clear_exp();
      for (int i = 0; i < OBUF_DEPTH; i++) exp_rows[i] = '0;
   endtask

   // called at a negedge; returns at the following negedge after the beat is taken
   task automatic push(input int addr, input orow_t d, input bit acc, input bit last);
      chk("push_arr_ready", W'(arr_ready), W'(1));
      arr_valid = 1'b1;
      arr_addr  = AW'(addr);
      arr_data  = d;
      arr_acc   = acc;
      arr_last  = last;
      @(negedge clk);
      arr_valid = 1'b0;
      arr_acc   = 1'b0;
      arr_last  = 1'b0;
   endtask

   // stall = 1 drives out_ready as 1,0,0,1,0,0,...
   task automatic drain(input int n, input bit stall);
      int  idx   = 0;
      int  k     = 0;
      int  guard = 0;
      bit  rdy;
      while (idx < n && guard < 400) begin
         guard++;
         chk($sformatf("out_valid[%0d]", idx), W'(out_valid), W'(1));
         chk($sformatf("busy[%0d]", idx), W'(busy), W'(1));
         chk($sformatf("arr_ready_drain[%0d]", idx), W'(arr_ready), W'(0));
         chk($sformatf("out_addr[%0d]", idx), W'(out_addr), W'(idx));
         chk($sformatf("out_data[%0d]", idx), out_data, exp_rows[idx]);
         chk($sformatf("out_last[%0d]", idx), W'(out_last), W'(idx == n - 1));
         rdy = stall ? (k % 3 == 0) : 1'b1;
         out_ready = rdy;
         k++;
         @(negedge clk);
         if (rdy) idx++;
      end
      chk("drain_complete", W'(idx), W'(n));
      out_ready = 1'b0;
      chk("tile_done_pulse", W'(tile_done), W'(1));
      chk("arr_ready_after", W'(arr_ready), W'(1));
      chk("out_valid_after", W'(out_valid), W'(0));
   endtask

   initial begin
      orow_t r;
      rst       = 1'b1;
      arr_valid = 1'b0;
      arr_addr  = '0;
      arr_data  = '0;
      arr_acc   = 1'b0;
      arr_last  = 1'b0;
      out_ready = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_arr_ready", W'(arr_ready), W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_last", W'(out_last), W'(0));
      chk("rst_tile_done", W'(tile_done), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_out_addr", W'(out_addr), W'(0));
      chk("rst_out_data", out_data, '0);
      rst = 1'b0;
      #1;
      chk("post_rst_arr_ready", W'(arr_ready), W'(1));
      @(negedge clk);

      // 1: rows 0..3, last on 3; out_ready high in FILL must be harmless
      out_ready = 1'b1;
      clear_exp();
      for (int i = 0; i < 4; i++) begin
         exp_rows[i] = row_lanes(i);
         push(i, row_lanes(i), 1'b0, i == 3);
      end
      drain(4, 1'b0);
      @(negedge clk);
      chk("tile_done_one_cycle", W'(tile_done), W'(0));

      // 2: write 5, acc 7, acc 7 + last into row 2; rows 0/1 are holes
      clear_exp();
      exp_rows[2] = row_const(32'd19);
      push(2, row_const(32'd5), 1'b0, 1'b0);
      push(2, row_const(32'd7), 1'b1, 1'b0);
      push(2, row_const(32'd7), 1'b1, 1'b1);
      drain(3, 1'b0);

      // 3: lane wrap without carry into the neighbouring lane
      clear_exp();
      r = '0;
      r[0] = 32'hFFFF_FFFF;
      r[1] = 32'd5;
      r[2] = 32'hFFFF_FFFF;
      push(0, r, 1'b0, 1'b0);
      r = '0;
      r[0] = 32'd2;
      push(0, r, 1'b1, 1'b1);
      exp_rows[0][0] = 32'h0000_0001;
      exp_rows[0][1] = 32'd5;
      exp_rows[0][2] = 32'hFFFF_FFFF;
      drain(1, 1'b0);

      // 4: stalled drain while the array holds a beat for row 5
      clear_exp();
      for (int i = 0; i < 3; i++) begin
         exp_rows[i] = row_lanes(i + 40);
         push(i, row_lanes(i + 40), 1'b0, i == 2);
      end
      arr_valid = 1'b1;
      arr_addr  = AW'(5);
      arr_data  = row_lanes(77);
      arr_acc   = 1'b1;
      arr_last  = 1'b1;
      drain(3, 1'b1);
      @(negedge clk);
      arr_valid = 1'b0;
      arr_acc   = 1'b0;
      arr_last  = 1'b0;
      clear_exp();
      exp_rows[5] = row_lanes(77);
      drain(6, 1'b0);

      // 5: top address gives a full-depth drain, then acc into a cleared row 0
      clear_exp();
      exp_rows[31] = row_lanes(31);
      push(31, row_lanes(31), 1'b0, 1'b1);
      drain(32, 1'b0);
      clear_exp();
      exp_rows[0] = row_const(32'd9);
      push(0, row_const(32'd9), 1'b1, 1'b1);
      drain(1, 1'b0);

      // 6: reset in the middle of a drain
      for (int i = 0; i < 4; i++) push(i, row_lanes(i + 100), 1'b0, i == 3);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_out_addr", W'(out_addr), W'(2));
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", W'(out_valid), W'(0));
      chk("mid_rst_busy", W'(busy), W'(0));
      chk("mid_rst_arr_ready", W'(arr_ready), W'(0));
      chk("mid_rst_out_addr", W'(out_addr), W'(0));
      chk("mid_rst_out_data", out_data, '0);
      chk("mid_rst_out_last", W'(out_last), W'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_release_ready", W'(arr_ready), W'(1));
      @(negedge clk);
      clear_exp();
      exp_rows[0] = row_const(32'hAB);
      push(0, row_const(32'hAB), 1'b1, 1'b1);
      drain(1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
